decoder_3to8: RTL and testbench

- 3-to-8 line decoder with active-high enable and one-hot, active-high outputs.
- Select inputs A, B, C form a 3-bit code, with A as the MSB.
- Outputs are registered on the clock by default, giving glitch-free, timing-clean one-hot strobes to downstream logic.
- Used as a generic address/strobe decoder in control paths.

---
 rtl/decoder_pkg.sv | 24 ++
 rtl/decoder_3to8_if.sv | 21 ++
 rtl/decoder_3to8_core.sv | 10 +
 rtl/decoder_3to8.sv | 55 +++++
 tb/tb_decoder_3to8.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths and one-hot decode helper for the 3-to-8 decoder
package decoder_pkg;

    localparam int SEL_W   = 3;
    localparam int NUM_OUT = 8;

    // Produces at most one set bit: bit sel when enabled, all-zero otherwise.
    function automatic logic [NUM_OUT-1:0] onehot_decode(
        input logic [SEL_W-1:0] sel,
        input logic             en
    );
        logic [NUM_OUT-1:0] vec;
        vec = '0;
        if (en) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (sel == SEL_W'(i)) begin
                    vec[i] = 1'b1;
                end
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/decoder_3to8_if.sv
// rtl/decoder_3to8_if.sv - select/enable bus and decoded line vector
interface decoder_3to8_if;
    import decoder_pkg::*;

    logic [SEL_W-1:0]   sel;
    logic               en;
    logic [NUM_OUT-1:0] y;

    modport master (
        output sel,
        output en,
        input  y
    );

    modport slave (
        input  sel,
        input  en,
        output y
    );

endinterface

// File: rtl/decoder_3to8_core.sv
// rtl/decoder_3to8_core.sv - purely combinational select/enable to one-hot decode
module decoder_3to8_core
    import decoder_pkg::*;
(
    decoder_3to8_if.slave dec
);

    assign dec.y = onehot_decode(dec.sel, dec.en);

endmodule

// File: rtl/decoder_3to8.sv
// rtl/decoder_3to8.sv - 3-to-8 line decoder with optional registered outputs
module decoder_3to8
    import decoder_pkg::*;
#(
    parameter int REG_OUT = 1
) (
    output logic Y7,
    output logic Y6,
    output logic Y5,
    output logic Y4,
    output logic Y3,
    output logic Y2,
    output logic Y1,
    output logic Y0,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic en,
    input  logic clk,
    input  logic rst
);

    decoder_3to8_if dec_bus ();

    logic [NUM_OUT-1:0] y;

    assign dec_bus.sel = {A, B, C};
    assign dec_bus.en  = en;

    decoder_3to8_core u_core (
        .dec (dec_bus.slave)
    );

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [NUM_OUT-1:0] y_q;

            // Reset clears the strobes immediately so no stale line survives a reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    y_q <= '0;
                end else begin
                    y_q <= dec_bus.y;
                end
            end

            assign y = y_q;
        end else begin : g_comb
            assign y = dec_bus.y;
        end
    endgenerate

    assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y;

endmodule

// File: tb/tb_decoder_3to8.sv
// tb/tb_decoder_3to8.sv - randomized self-checking bench for registered and combinational builds
module tb_decoder_3to8;

    logic       clk;
    logic       rst;
    logic [7:0] y_reg;
    logic [7:0] y_comb;
    logic [7:0] exp_reg;
    int         n_tests;
    int         n_fail;

    decoder_3to8_if stim ();

    decoder_3to8 #(.REG_OUT(1)) u_dut_reg (
        .Y7  (y_reg[7]),
        .Y6  (y_reg[6]),
        .Y5  (y_reg[5]),
        .Y4  (y_reg[4]),
        .Y3  (y_reg[3]),
        .Y2  (y_reg[2]),
        .Y1  (y_reg[1]),
        .Y0  (y_reg[0]),
        .A   (stim.sel[2]),
        .B   (stim.sel[1]),
        .C   (stim.sel[0]),
        .en  (stim.en),
        .clk (clk),
        .rst (rst)
    );

    decoder_3to8 #(.REG_OUT(0)) u_dut_comb (
        .Y7  (y_comb[7]),
        .Y6  (y_comb[6]),
        .Y5  (y_comb[5]),
        .Y4  (y_comb[4]),
        .Y3  (y_comb[3]),
        .Y2  (y_comb[2]),
        .Y1  (y_comb[1]),
        .Y0  (y_comb[0]),
        .A   (stim.sel[2]),
        .B   (stim.sel[1]),
        .C   (stim.sel[0]),
        .en  (stim.en),
        .clk (clk),
        .rst (rst)
    );

    assign stim.y = y_reg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] ref_dec(input logic e, input logic [2:0] s);
        logic [7:0] one;
        one = 8'h01;
        return e ? (one << s) : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_onehot(input string tag);
        check({tag, "_onehot_reg"}, 8'($countones(y_reg) <= 1), 8'd1);
        check({tag, "_onehot_comb"}, 8'($countones(y_comb) <= 1), 8'd1);
    endtask

    // Called just after a falling edge; drives inputs, checks both builds across one rising edge.
    task automatic apply(input string tag, input logic e, input logic [2:0] s);
        stim.en  = e;
        stim.sel = s;
        #1;
        check({tag, "_comb"}, y_comb, ref_dec(e, s));
        check({tag, "_hold"}, y_reg, exp_reg);
        @(posedge clk);
        exp_reg = rst ? 8'h00 : ref_dec(e, s);
        @(negedge clk);
        check({tag, "_reg"}, y_reg, exp_reg);
        check_onehot(tag);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_reg  = 8'h00;
        rst      = 1'b1;
        stim.en  = 1'b1;
        stim.sel = 3'b111;

        #3;
        check("rst_immediate", y_reg, 8'h00);
        check("rst_comb_ignores", y_comb, 8'h80);
        @(posedge clk);
        @(negedge clk);
        check("rst_held", y_reg, 8'h00);
        rst = 1'b0;
        @(posedge clk);
        exp_reg = 8'h80;
        @(negedge clk);
        check("rst_release_load", y_reg, exp_reg);

        for (int i = 0; i < 8; i++) begin
            apply("disabled", 1'b0, 3'(i));
        end

        apply("en_seq0", 1'b1, 3'b000);
        apply("en_seq2", 1'b1, 3'b010);
        apply("en_seq4", 1'b1, 3'b100);
        apply("en_seq6", 1'b1, 3'b110);

        apply("drop_pre", 1'b1, 3'b110);
        apply("drop_en", 1'b0, 3'b110);
        apply("drop_sel_chg_pre", 1'b1, 3'b001);
        apply("drop_sel_chg", 1'b0, 3'b101);

        for (int i = 0; i < 16; i++) begin
            apply("exhaustive", i[3], i[2:0]);
        end

        apply("mid_pre", 1'b1, 3'b011);
        #2;
        rst = 1'b1;
        #1;
        exp_reg = 8'h00;
        check("mid_rst_async", y_reg, 8'h00);
        check("mid_rst_comb", y_comb, 8'h08);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_held", y_reg, 8'h00);
        stim.sel = 3'b101;
        rst = 1'b0;
        @(posedge clk);
        exp_reg = ref_dec(stim.en, stim.sel);
        @(negedge clk);
        check("mid_rst_release", y_reg, exp_reg);

        for (int i = 0; i < 200; i++) begin
            apply("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
